// File: rtl/control_word_sequencer_if.sv
// ============================================================================
// control_word_sequencer_if : controlWord/nextState handshake between decoders
//                             and the control word sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface control_word_sequencer_if;
    logic        cw_valid;
    logic        cw_ready;
    logic [28:0] controlWord;
    logic [1:0]  nextState;

    modport master (output cw_valid, output controlWord, output nextState, input  cw_ready);
    modport slave  (input  cw_valid, input  controlWord, input  nextState, output cw_ready);
endinterface

`default_nettype wire

// File: rtl/control_word_sequencer.sv
// ============================================================================
// control_word_sequencer : latches decoder control words, holds the instruction
//                          state register and stalls RAM words until mem_ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_word_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire                              clock,
    input  wire                              reset,
    control_word_sequencer_if.slave          cw,
    input  wire                              mem_ready,
    output logic [1:0]                       state,
    output logic [1:0]                       Psel,
    output logic [4:0]                       DA,
    output logic [4:0]                       SA,
    output logic [4:0]                       SB,
    output logic [4:0]                       Fsel,
    output logic                             regW,
    output logic                             ramW,
    output logic [1:0]                       Dsel,
    output logic                             Bsel,
    output logic                             PCsel,
    output logic                             SL,
    output logic                             retire,
    output logic                             mem_error
);

    typedef enum logic [0:0] {
        S_EXEC     = 1'b0,
        S_WAIT_MEM = 1'b1
    } fsm_t;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    fsm_t        fsm_q;
    logic [28:0] fld_q;
    logic [1:0]  state_q;
    logic [7:0]  cnt_q;
    logic        regw_q;
    logic        ramw_q;
    logic        retire_q;
    logic        err_q;

    logic        w_accept;
    logic        w_is_mem;

    assign cw.cw_ready = (fsm_q == S_EXEC);
    assign w_accept    = cw.cw_valid && (fsm_q == S_EXEC);
    // A word touches RAM when it writes memory or selects RAM onto the data bus.
    assign w_is_mem    = cw.controlWord[5] || (cw.controlWord[4:3] == 2'b10);

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q    <= S_EXEC;
            fld_q    <= '0;
            state_q  <= 2'b00;
            cnt_q    <= '0;
            regw_q   <= 1'b0;
            ramw_q   <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            regw_q   <= 1'b0;
            ramw_q   <= 1'b0;
            retire_q <= 1'b0;
            case (fsm_q)
                S_EXEC: begin
                    if (w_accept) begin
                        fld_q   <= cw.controlWord;
                        state_q <= cw.nextState;
                        if (w_is_mem) begin
                            fsm_q  <= S_WAIT_MEM;
                            cnt_q  <= '0;
                            ramw_q <= cw.controlWord[5];
                        end else begin
                            regw_q   <= cw.controlWord[6];
                            ramw_q   <= cw.controlWord[5];
                            retire_q <= (cw.nextState == 2'b00);
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_ready) begin
                        regw_q   <= fld_q[6];
                        ramw_q   <= fld_q[5];
                        retire_q <= (state_q == 2'b00);
                        fsm_q    <= S_EXEC;
                    end else if (cnt_q == c_TIMEOUT_LAST) begin
                        // Abort: drop the access and restart the decoder from state 00.
                        err_q   <= 1'b1;
                        state_q <= 2'b00;
                        fsm_q   <= S_EXEC;
                    end else begin
                        cnt_q  <= cnt_q + 8'd1;
                        ramw_q <= fld_q[5];
                    end
                end
                default: fsm_q <= S_EXEC;
            endcase
        end
    end

    assign state     = state_q;
    assign Psel      = fld_q[28:27];
    assign DA        = fld_q[26:22];
    assign SA        = fld_q[21:17];
    assign SB        = fld_q[16:12];
    assign Fsel      = fld_q[11:7];
    assign regW      = regw_q;
    assign ramW      = ramw_q;
    assign Dsel      = fld_q[4:3];
    assign Bsel      = fld_q[2];
    assign PCsel     = fld_q[1];
    assign SL        = fld_q[0];
    assign retire    = retire_q;
    assign mem_error = err_q;

endmodule

`default_nettype wire

// File: tb/tb_control_word_sequencer.sv
// ============================================================================
// tb_control_word_sequencer : directed + randomized check of the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_word_sequencer;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [1:0]  state, Psel, Dsel;
    logic [4:0]  DA, SA, SB, Fsel;
    logic        regW, ramW, Bsel, PCsel, SL, retire, mem_error;

    control_word_sequencer_if cw ();

    control_word_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .cw(cw.slave), .mem_ready(mem_ready),
        .state(state), .Psel(Psel), .DA(DA), .SA(SA), .SB(SB), .Fsel(Fsel),
        .regW(regW), .ramW(ramW), .Dsel(Dsel), .Bsel(Bsel), .PCsel(PCsel),
        .SL(SL), .retire(retire), .mem_error(mem_error)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_err = 0;
    logic        exp_err;
    logic [28:0] last_w;
    logic [1:0]  last_st;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected outputs for one cycle: held fields of word w plus the control bits.
    task automatic check_cycle(input string tag, input logic [28:0] w, input logic rdy,
                               input logic rw, input logic mw, input logic ret, input logic [1:0] st);
        logic [31:0] act_f, exp_f;
        act_f = {3'b0, Psel, DA, SA, SB, Fsel, 2'b00, Dsel, Bsel, PCsel, SL};
        exp_f = {3'b0, w[28:7], 2'b00, w[4:0]};
        check({tag, "_fields"}, act_f, exp_f);
        check({tag, "_ctl"}, {25'b0, cw.cw_ready, regW, ramW, retire, mem_error, state},
              {25'b0, rdy, rw, mw, ret, exp_err, st});
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic is_mem(input logic [28:0] w);
        return w[5] || (w[4:3] == 2'b10);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cw.cw_valid = 1'b0;
            cw.controlWord = 29'($urandom);
            mem_ready = 1'($urandom_range(0, 1));
            step();
            mem_ready = 1'b0;
            check_cycle("idle", last_w, 1'b1, 1'b0, 1'b0, 1'b0, last_st);
        end
    endtask

    // One instruction word; d = cycle of WAIT_MEM in which mem_ready rises, 0 = never.
    task automatic run_txn(input logic [28:0] w, input logic [1:0] ns, input int d);
        check("ready_pre", {31'b0, cw.cw_ready}, 32'd1);
        cw.cw_valid    = 1'b1;
        cw.controlWord = w;
        cw.nextState   = ns;
        mem_ready      = 1'($urandom_range(0, 1));
        step();
        cw.cw_valid = 1'b0;
        mem_ready   = 1'b0;
        last_w  = w;
        last_st = ns;
        if (!is_mem(w)) begin
            check_cycle("alu", w, 1'b1, w[6], w[5], ns == 2'b00, ns);
            return;
        end
        for (int i = 1; i <= TO; i++) begin
            check_cycle("wait", w, 1'b0, 1'b0, w[5], 1'b0, ns);
            cw.cw_valid    = 1'($urandom_range(0, 1));
            cw.controlWord = 29'($urandom);
            cw.nextState   = 2'($urandom);
            mem_ready      = (i == d);
            step();
            cw.cw_valid = 1'b0;
            mem_ready   = 1'b0;
            if (i == d) break;
        end
        if (d != 0) begin
            check_cycle("done", w, 1'b1, w[6], w[5], ns == 2'b00, ns);
        end else begin
            exp_err = 1'b1;
            last_st = 2'b00;
            check_cycle("timeout", w, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        end
    endtask

    initial begin
        logic [28:0] w;
        int          d;
        reset = 1'b1;
        mem_ready = 1'b0;
        cw.cw_valid = 1'b0;
        cw.controlWord = '0;
        cw.nextState = 2'b00;
        exp_err = 1'b0;
        last_w  = '0;
        last_st = 2'b00;
        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        check_cycle("reset", '0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        // ADDI: Psel=01, DA=5, regW=1, Dsel=01, Bsel=1
        w = {2'b01, 5'd5, 5'd3, 5'd0, 5'd2, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};
        run_txn(w, 2'b00, 1);
        idle(1);
        // store, mem_ready in third WAIT_MEM cycle
        w = {2'b01, 5'd0, 5'd4, 5'd6, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        run_txn(w, 2'b00, 3);
        // two-state instruction: only the follow-up retires
        w = {2'b10, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        run_txn(w, 2'b01, 1);
        w = {2'b10, 5'd7, 5'd2, 5'd3, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1};
        run_txn(w, 2'b00, 1);
        // load answered in the last allowed cycle
        w = {2'b00, 5'd9, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        run_txn(w, 2'b00, TO);
        // load never answered
        run_txn(w, 2'b00, 0);
        idle(2);

        for (int k = 0; k < 150; k++) begin
            w = 29'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            run_txn(w, 2'($urandom), d);
            idle(int'($urandom_range(0, 2)));
        end

        // reset two cycles into WAIT_MEM
        w = {2'b11, 5'd8, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1};
        cw.cw_valid = 1'b1;
        cw.controlWord = w;
        cw.nextState = 2'b10;
        step();
        cw.cw_valid = 1'b0;
        check_cycle("wait1", w, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        step();
        check_cycle("wait2", w, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_err = 1'b0;
        check_cycle("mid_reset", '0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
